// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and access-fault check for dmem_responder
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // True when the access must fault: bad size code, misaligned lane or outside the RAM window.
    function automatic logic dmem_access_err(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] base_addr,
        input logic [32:0] size_bytes
    );
        logic [31:0] offset;
        logic        bad_size;
        logic        bad_align;
        logic        bad_range;
        offset    = addr - base_addr;
        bad_range = (addr < base_addr) || ({1'b0, offset} >= size_bytes);
        if (write) begin
            bad_size = (funct3 > F3_W);
        end else begin
            bad_size = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        bad_align = ((funct3[1:0] == 2'b01) && offset[0]) ||
                    ((funct3[1:0] == 2'b10) && (offset[1:0] != 2'b00));
        return bad_size | bad_align | bad_range;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte/halfword lane extraction for loads and lane merge for stores
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword and extend it according to the load type.
    always_comb begin
        byte_sel  = rd_word[7:0];
        load_data = '0;
        case (lane)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Merge the right-justified store data into the addressed lane, keeping other bytes.
    always_comb begin
        store_word = rd_word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0]  = wdata[15:0];
                end
            end
            F3_W:    store_word = wdata;
            default: store_word = rd_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and access-fault reporting
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int            AW         = $clog2(DEPTH_WORDS);
    localparam int            CW         = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [32:0]   SIZE_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [CW-1:0] CNT_LOAD   = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [1:0]    ST_IDLE    = 2'(IDLE);
    localparam logic [1:0]    ST_WAIT    = 2'(WAIT);
    localparam logic [1:0]    ST_RESP    = 2'(RESP);

    logic [1:0]    state_q, state_d;
    logic          ready_q;
    logic [CW-1:0] count_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          cur_write;
    logic [31:0]   cur_addr;
    logic [2:0]    cur_funct3;
    logic [31:0]   cur_wdata;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;
    logic [31:0]   store_word;
    logic          access_err;

    // ready_q is 0 throughout reset, so nothing can be accepted or committed then.
    assign accept = req_valid_i & ready_q;

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_write  = (state_q == ST_IDLE) ? req_write_i  : write_q;
    assign cur_addr   = (state_q == ST_IDLE) ? req_addr_i   : addr_q;
    assign cur_funct3 = (state_q == ST_IDLE) ? req_funct3_i : funct3_q;
    assign cur_wdata  = (state_q == ST_IDLE) ? req_wdata_i  : wdata_q;

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state_q == ST_WAIT) && (count_q == '0));

    assign offset     = cur_addr - BASE_ADDR;
    assign word_idx   = AW'(offset >> 2);
    assign rd_word    = mem[word_idx];
    assign access_err = dmem_access_err(cur_write, cur_funct3, cur_addr, BASE_ADDR, SIZE_BYTES);

    dmem_lane_align u_align (
        .rd_word    (rd_word),
        .lane       (offset[1:0]),
        .funct3     (cur_funct3),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Next-state logic: accept in IDLE, count down in WAIT, hold RESP until handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (count_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, request latch and response registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            count_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                write_q  <= req_write_i;
                addr_q   <= req_addr_i;
                funct3_q <= req_funct3_i;
                wdata_q  <= req_wdata_i;
                count_q  <= CNT_LOAD;
            end else if ((state_q == ST_WAIT) && (count_q != '0)) begin
                count_q <= count_q - 1'b1;
            end
            if (enter_resp) begin
                rsp_err_q   <= access_err;
                rsp_rdata_q <= (access_err || cur_write) ? '0 : load_data;
            end
        end
    end

    // RAM write at the commit edge; faulting stores leave memory untouched.
    always_ff @(posedge clk_i) begin
        if (enter_resp && cur_write && !access_err) begin
            mem[word_idx] <= store_word;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
